// File: rtl/tx_phyretrain_hs_if.sv
// Handshake bundle between the LTSM/sideband wrapper and the PHYRETRAIN TX handshake block.
// The master side drives the block's inputs; the slave modport is the block itself.
interface tx_phyretrain_hs_if #(
   parameter int SB_MSG_WIDTH = 4,
   parameter int RETRY_W      = 2
);
   logic                    i_phyretrain_en;
   logic                    i_enter_from_active_or_mbtrain;
   logic [1:0]              i_linkspeed_lanes_status;
   logic                    i_falling_edge_busy;
   logic                    i_rx_valid;
   logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg;
   logic                    i_rx_msg_valid;
   logic [2:0]              i_rx_msg_info;
   logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_tx;
   logic [2:0]              o_msg_info;
   logic [2:0]              o_resolved_info;
   logic                    o_valid_tx;
   logic                    o_phyretrain_end_tx;
   logic                    o_timeout_err;
   logic [RETRY_W-1:0]      o_retry_cnt;

   modport master (
      output i_phyretrain_en, i_enter_from_active_or_mbtrain, i_linkspeed_lanes_status,
             i_falling_edge_busy, i_rx_valid, i_decoded_SB_msg, i_rx_msg_valid, i_rx_msg_info,
      input  o_encoded_SB_msg_tx, o_msg_info, o_resolved_info, o_valid_tx,
             o_phyretrain_end_tx, o_timeout_err, o_retry_cnt
   );

   modport slave (
      input  i_phyretrain_en, i_enter_from_active_or_mbtrain, i_linkspeed_lanes_status,
             i_falling_edge_busy, i_rx_valid, i_decoded_SB_msg, i_rx_msg_valid, i_rx_msg_info,
      output o_encoded_SB_msg_tx, o_msg_info, o_resolved_info, o_valid_tx,
             o_phyretrain_end_tx, o_timeout_err, o_retry_cnt
   );
endinterface

// File: rtl/tx_phyretrain_hs.sv
// PHYRETRAIN start handshake, TX side: sends the start request, waits for the partner's
// response with bounded re-sends, and resolves the retrain type from both sides' encodings.
module tx_phyretrain_hs #(
   parameter int SB_MSG_WIDTH   = 4,
   parameter int TIMEOUT_CYCLES = 8000,
   parameter int TIMER_W        = 16,
   parameter int MAX_RETRIES    = 3,
   parameter int RETRY_W        = 2,
   parameter int REQ_CODE       = 1,
   parameter int RESP_CODE      = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   tx_phyretrain_hs_if.slave bus
);

   localparam logic [TIMER_W-1:0]      TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [RETRY_W-1:0]      RETRY_MAX  = RETRY_W'(MAX_RETRIES);
   localparam logic [SB_MSG_WIDTH-1:0] REQ_MSG    = SB_MSG_WIDTH'(REQ_CODE);
   localparam logic [SB_MSG_WIDTH-1:0] RESP_MSG   = SB_MSG_WIDTH'(RESP_CODE);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SEND_REQ  = 3'd1,
      WAIT_RESP = 3'd2,
      DONE      = 3'd3,
      ERROR     = 3'd4
   } state_t;

   state_t                  state;
   logic [TIMER_W-1:0]      timer;
   logic [RETRY_W-1:0]      retry_cnt;
   logic [2:0]              msg_info;
   logic [2:0]              resolved_info;
   logic [2:0]              partner_info;
   logic [SB_MSG_WIDTH-1:0] encoded_msg;
   logic                    valid_tx;
   logic                    end_tx;
   logic                    timeout_err;

   logic       is_resp;
   logic       is_partner_req;
   logic       valid_clear;
   logic [2:0] local_info;
   logic [2:0] merged_info;
   logic [2:0] resolved_next;

   assign is_resp        = bus.i_rx_msg_valid && (bus.i_decoded_SB_msg == RESP_MSG);
   assign is_partner_req = bus.i_rx_msg_valid && (bus.i_decoded_SB_msg == REQ_MSG);
   assign valid_clear    = bus.i_falling_edge_busy && !bus.i_rx_valid;
   // Partner info is zero until captured, so OR-ing it in is a no-op when nothing arrived.
   assign merged_info    = msg_info | partner_info;

   always_comb begin
      local_info = 3'b001;
      if (bus.i_enter_from_active_or_mbtrain) begin
         case (bus.i_linkspeed_lanes_status)
            2'd2:    local_info = 3'b100;
            2'd3:    local_info = 3'b010;
            default: local_info = 3'b001;
         endcase
      end
   end

   always_comb begin
      resolved_next = 3'b001;
      if (merged_info[1]) begin
         resolved_next = 3'b010;
      end else if (merged_info[2]) begin
         resolved_next = 3'b100;
      end
   end

   // Valid clearing is written first so any request send later in the block overrides it.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state         <= IDLE;
         timer         <= '0;
         retry_cnt     <= '0;
         msg_info      <= '0;
         resolved_info <= '0;
         partner_info  <= '0;
         encoded_msg   <= '0;
         valid_tx      <= 1'b0;
         end_tx        <= 1'b0;
         timeout_err   <= 1'b0;
      end else begin
         if (valid_clear) begin
            valid_tx <= 1'b0;
         end
         if (state != IDLE && is_partner_req) begin
            partner_info <= bus.i_rx_msg_info;
         end
         if (state != IDLE && !bus.i_phyretrain_en) begin
            state       <= IDLE;
            valid_tx    <= 1'b0;
            encoded_msg <= '0;
            end_tx      <= 1'b0;
            timeout_err <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.i_phyretrain_en) begin
                     state         <= SEND_REQ;
                     retry_cnt     <= '0;
                     resolved_info <= '0;
                     partner_info  <= '0;
                     msg_info      <= local_info;
                     encoded_msg   <= REQ_MSG;
                     valid_tx      <= 1'b1;
                     timer         <= '0;
                  end
               end
               SEND_REQ: begin
                  state <= WAIT_RESP;
               end
               WAIT_RESP: begin
                  // A response arriving on the last timer cycle still completes the handshake.
                  if (is_resp) begin
                     state         <= DONE;
                     end_tx        <= 1'b1;
                     resolved_info <= resolved_next;
                  end else if (timer == TIMER_LAST) begin
                     if (retry_cnt < RETRY_MAX) begin
                        state       <= SEND_REQ;
                        retry_cnt   <= retry_cnt + RETRY_W'(1);
                        msg_info    <= local_info;
                        encoded_msg <= REQ_MSG;
                        valid_tx    <= 1'b1;
                        timer       <= '0;
                     end else begin
                        state       <= ERROR;
                        timeout_err <= 1'b1;
                     end
                  end else begin
                     timer <= timer + TIMER_W'(1);
                  end
               end
               DONE, ERROR: begin
                  state <= state;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.o_encoded_SB_msg_tx = encoded_msg;
   assign bus.o_msg_info          = msg_info;
   assign bus.o_resolved_info     = resolved_info;
   assign bus.o_valid_tx          = valid_tx;
   assign bus.o_phyretrain_end_tx = end_tx;
   assign bus.o_timeout_err       = timeout_err;
   assign bus.o_retry_cnt         = retry_cnt;

endmodule

// File: tb/tb_tx_phyretrain_hs.sv
// Self-checking bench for tx_phyretrain_hs: directed scenarios plus randomized sessions
// whose expected outputs come from a cycle-count model of the handshake timeline.
module tb_tx_phyretrain_hs;

   localparam int SB_W   = 4;
   localparam int TO     = 16;
   localparam int MAXR   = 2;
   localparam int RW     = 2;
   localparam int REQ    = 1;
   localparam int RESP   = 2;
   localparam int PERIOD = TO + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   tx_phyretrain_hs_if #(.SB_MSG_WIDTH(SB_W), .RETRY_W(RW)) bus ();

   tx_phyretrain_hs #(
      .SB_MSG_WIDTH(SB_W), .TIMEOUT_CYCLES(TO), .TIMER_W(16), .MAX_RETRIES(MAXR),
      .RETRY_W(RW), .REQ_CODE(REQ), .RESP_CODE(RESP)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   // Packed view: {encoded, msg_info, resolved, valid, end, timeout, retry_cnt}
   function automatic logic [14:0] observed();
      return {bus.o_encoded_SB_msg_tx, bus.o_msg_info, bus.o_resolved_info, bus.o_valid_tx,
              bus.o_phyretrain_end_tx, bus.o_timeout_err, bus.o_retry_cnt};
   endfunction

   function automatic logic [2:0] model_msg_info(input logic src, input logic [1:0] lane);
      if (!src) return 3'b001;
      if (lane == 2'd2) return 3'b100;
      if (lane == 2'd3) return 3'b010;
      return 3'b001;
   endfunction

   function automatic logic [2:0] model_resolve(input logic [2:0] mine, input logic [2:0] peer);
      logic [2:0] both;
      both = mine | peer;
      if (both[1]) return 3'b010;
      if (both[2]) return 3'b100;
      return 3'b001;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.i_phyretrain_en                = 1'b0;
      bus.i_enter_from_active_or_mbtrain = 1'b0;
      bus.i_linkspeed_lanes_status       = 2'd0;
      bus.i_falling_edge_busy            = 1'b0;
      bus.i_rx_valid                     = 1'b0;
      bus.i_decoded_SB_msg               = '0;
      bus.i_rx_msg_valid                 = 1'b0;
      bus.i_rx_msg_info                  = 3'b000;
   endtask

   task automatic test_reset();
      idle_inputs();
      bus.i_phyretrain_en = 1'b1;
      rst_n = 1'b0;
      step();
      step();
      checks++;
      if (observed() !== 15'h0) begin
         errors++;
         $display("[TB] FAIL reset_state: got %h expected %h", observed(), 15'h0);
      end
      rst_n = 1'b1;
      bus.i_phyretrain_en = 1'b0;
      step();
      checks++;
      if (observed() !== 15'h0) begin
         errors++;
         $display("[TB] FAIL reset_release_idle: got %h expected %h", observed(), 15'h0);
      end
   endtask

   task automatic test_basic();
      idle_inputs();
      bus.i_linkspeed_lanes_status = 2'($urandom_range(0, 3));
      bus.i_phyretrain_en = 1'b1;
      step();
      checks++;
      if ({bus.o_encoded_SB_msg_tx, bus.o_valid_tx, bus.o_msg_info} !== {4'(REQ), 1'b1, 3'b001}) begin
         errors++;
         $display("[TB] FAIL basic_request: got enc=%0d valid=%b info=%b expected enc=%0d valid=1 info=001",
                  bus.o_encoded_SB_msg_tx, bus.o_valid_tx, bus.o_msg_info, REQ);
      end
      for (int i = 0; i < 6; i++) step();
      checks++;
      if (bus.o_phyretrain_end_tx !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_not_done_early: got %b expected 0", bus.o_phyretrain_end_tx);
      end
      bus.i_rx_msg_valid   = 1'b1;
      bus.i_decoded_SB_msg = 4'(RESP);
      step();
      bus.i_rx_msg_valid = 1'b0;
      checks++;
      if ({bus.o_phyretrain_end_tx, bus.o_retry_cnt, bus.o_resolved_info, bus.o_timeout_err}
          !== {1'b1, 2'd0, 3'b001, 1'b0}) begin
         errors++;
         $display("[TB] FAIL basic_done: got end=%b retry=%0d res=%b to=%b expected end=1 retry=0 res=001 to=0",
                  bus.o_phyretrain_end_tx, bus.o_retry_cnt, bus.o_resolved_info, bus.o_timeout_err);
      end
      bus.i_phyretrain_en = 1'b0;
      step();
      checks++;
      if (observed() !== {4'd0, 3'b001, 3'b001, 1'b0, 1'b0, 1'b0, 2'd0}) begin
         errors++;
         $display("[TB] FAIL basic_disable: got %h expected %h", observed(),
                  {4'd0, 3'b001, 3'b001, 1'b0, 1'b0, 1'b0, 2'd0});
      end
   endtask

   task automatic test_valid_clear();
      idle_inputs();
      bus.i_phyretrain_en = 1'b1;
      step();
      bus.i_falling_edge_busy = 1'b1;
      bus.i_rx_valid          = 1'b1;
      step();
      checks++;
      if (bus.o_valid_tx !== 1'b1) begin
         errors++;
         $display("[TB] FAIL valid_held_while_rx: got %b expected 1", bus.o_valid_tx);
      end
      bus.i_rx_valid = 1'b0;
      step();
      checks++;
      if (bus.o_valid_tx !== 1'b0) begin
         errors++;
         $display("[TB] FAIL valid_cleared: got %b expected 0", bus.o_valid_tx);
      end
      idle_inputs();
      step();
   endtask

   task automatic test_abort();
      idle_inputs();
      bus.i_enter_from_active_or_mbtrain = 1'b1;
      bus.i_linkspeed_lanes_status       = 2'd3;
      bus.i_phyretrain_en                = 1'b1;
      step();
      for (int i = 0; i < PERIOD + 8; i++) step();
      checks++;
      if (bus.o_retry_cnt !== 2'd1) begin
         errors++;
         $display("[TB] FAIL abort_retry_before: got %0d expected 1", bus.o_retry_cnt);
      end
      bus.i_phyretrain_en = 1'b0;
      step();
      checks++;
      if (observed() !== {4'd0, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 2'd1}) begin
         errors++;
         $display("[TB] FAIL abort_en_drop: got %h expected %h", observed(),
                  {4'd0, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 2'd1});
      end
      bus.i_phyretrain_en = 1'b1;
      step();
      checks++;
      if ({bus.o_retry_cnt, bus.o_valid_tx, bus.o_encoded_SB_msg_tx} !== {2'd0, 1'b1, 4'(REQ)}) begin
         errors++;
         $display("[TB] FAIL abort_restart: got retry=%0d valid=%b enc=%0d expected retry=0 valid=1 enc=%0d",
                  bus.o_retry_cnt, bus.o_valid_tx, bus.o_encoded_SB_msg_tx, REQ);
      end
      for (int i = 0; i < 8; i++) step();
      rst_n = 1'b0;
      step();
      checks++;
      if (observed() !== 15'h0) begin
         errors++;
         $display("[TB] FAIL abort_reset: got %h expected %h", observed(), 15'h0);
      end
      rst_n = 1'b1;
      step();
      checks++;
      if ({bus.o_retry_cnt, bus.o_valid_tx, bus.o_msg_info} !== {2'd0, 1'b1, 3'b010}) begin
         errors++;
         $display("[TB] FAIL reset_restart: got retry=%0d valid=%b info=%b expected retry=0 valid=1 info=010",
                  bus.o_retry_cnt, bus.o_valid_tx, bus.o_msg_info);
      end
      idle_inputs();
      step();
   endtask

   // resp_attempt 0..MAXR picks the attempt that gets answered, anything larger means never.
   task automatic run_session(input string name, input logic src, input logic [1:0] lane,
                              input int resp_attempt, input int resp_t, input int n_partner,
                              input logic [2:0] p0_info, input logic [2:0] p1_info,
                              input logic hold_valid);
      logic        resp;
      int          resp_n, final_n, limit, p0, p1, np, sends;
      logic [2:0]  exp_msg, peer, exp_res;
      logic [1:0]  exp_retry;
      logic        exp_valid, exp_end, exp_to;
      logic [14:0] exp;
      resp    = (resp_attempt <= MAXR);
      resp_n  = resp_attempt * PERIOD + 1 + resp_t;
      final_n = resp ? resp_n + 1 : (MAXR + 1) * PERIOD;
      limit   = resp ? resp_n : final_n - 1;
      sends   = resp ? resp_attempt : MAXR;
      np = n_partner;
      p0 = -1;
      p1 = -1;
      if (limit < 2) np = 0;
      if (np > 0) p0 = 1 + int'($urandom % 32'(limit - 1));
      if (np == 2) begin
         if (p0 < limit - 1) p1 = p0 + 1 + int'($urandom % 32'(limit - 1 - p0));
         else np = 1;
      end
      peer    = (np == 0) ? 3'b000 : (np == 1) ? p0_info : p1_info;
      exp_msg = model_msg_info(src, lane);
      exp_res = resp ? model_resolve(exp_msg, peer) : 3'b000;

      idle_inputs();
      bus.i_enter_from_active_or_mbtrain = src;
      bus.i_linkspeed_lanes_status       = lane;
      bus.i_falling_edge_busy            = 1'b1;
      bus.i_rx_valid                     = hold_valid;
      bus.i_phyretrain_en                = 1'b1;
      for (int n = 0; n <= final_n + 3; n++) begin
         step();
         exp_retry = (n < final_n) ? 2'(n / PERIOD) : 2'(sends);
         exp_valid = hold_valid ? 1'b1 : ((n % PERIOD == 0) && (n / PERIOD <= sends));
         exp_end   = resp && (n >= final_n);
         exp_to    = !resp && (n >= final_n);
         exp       = {4'(REQ), exp_msg, exp_end ? exp_res : 3'b000, exp_valid, exp_end, exp_to, exp_retry};
         checks++;
         if (observed() !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, n, observed(), exp);
         end
         bus.i_rx_msg_valid   = 1'b0;
         bus.i_decoded_SB_msg = 4'($urandom);
         bus.i_rx_msg_info    = 3'($urandom);
         if ($urandom % 4 == 0) begin
            bus.i_rx_msg_valid   = 1'b1;
            bus.i_decoded_SB_msg = 4'(3 + $urandom % 13);
         end
         if (n == p0 || n == p1) begin
            bus.i_rx_msg_valid   = 1'b1;
            bus.i_decoded_SB_msg = 4'(REQ);
            bus.i_rx_msg_info    = (n == p0) ? p0_info : p1_info;
         end
         if (resp && n == resp_n) begin
            bus.i_rx_msg_valid   = 1'b1;
            bus.i_decoded_SB_msg = 4'(RESP);
         end
      end
      bus.i_phyretrain_en = 1'b0;
      bus.i_rx_msg_valid  = 1'b0;
      step();
      exp = {4'd0, exp_msg, exp_res, 1'b0, 1'b0, 1'b0, 2'(sends)};
      checks++;
      if (observed() !== exp) begin
         errors++;
         $display("[TB] FAIL %s disable: got %h expected %h", name, observed(), exp);
      end
      idle_inputs();
      step();
   endtask

   task automatic test_partner();
      run_session("partner_repair", 1'b1, 2'd2, 0, 9, 1, 3'b010, 3'b000, 1'b0);
      run_session("partner_latest", 1'b1, 2'd2, 1, 6, 2, 3'b010, 3'b001, 1'b0);
   endtask

   task automatic test_timeout();
      run_session("timeout_error", 1'b0, 2'd0, MAXR + 1, 0, 0, 3'b000, 3'b000, 1'b0);
   endtask

   task automatic test_same_cycle();
      run_session("resp_at_expiry", 1'b1, 2'd1, 0, TO - 1, 0, 3'b000, 3'b000, 1'b0);
      run_session("resp_last_attempt", 1'b1, 2'd3, MAXR, TO - 1, 1, 3'b100, 3'b000, 1'b0);
   endtask

   task automatic test_random();
      for (int s = 0; s < 25; s++) begin
         run_session("random_session", 1'($urandom), 2'($urandom), int'($urandom % 4),
                     int'($urandom % TO), int'($urandom % 3), 3'($urandom), 3'($urandom),
                     1'($urandom));
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_basic();
      test_valid_clear();
      test_abort();
      test_partner();
      test_timeout();
      test_same_cycle();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
